// File: rtl/term_project_pkg.sv
// Shared constants and FSM state type for the operand-entry front end.
package term_project_pkg;

  localparam int IDX_A    = 0;
  localparam int IDX_B    = 1;
  localparam int IDX_C    = 2;
  localparam int IDX_D    = 3;
  localparam int NUM_BTNS = 4;
  localparam int ELEMS    = 8;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } entry_state_e;

endpackage

// File: rtl/vector_entry_ctrl_if.sv
// Button input and vector/entry-state outputs bundled between the entry stage and its consumer.
interface vector_entry_ctrl_if #(
  parameter int ELEMS = 8
);
  logic [7:0]               btn_sw;
  logic [ELEMS*8-1:0]       vec_a;
  logic [ELEMS*8-1:0]       vec_b;
  logic                     vec_valid;
  logic                     done_pulse;
  logic                     wr_strobe;
  logic [7:0]               entry_byte;
  logic [3:0]               bit_cnt;
  logic [$clog2(ELEMS)-1:0] elem_idx;
  logic                     vec_sel;

  modport master (
    input  btn_sw,
    output vec_a, vec_b, vec_valid, done_pulse, wr_strobe,
    output entry_byte, bit_cnt, elem_idx, vec_sel
  );

  modport slave (
    output btn_sw,
    input  vec_a, vec_b, vec_valid, done_pulse, wr_strobe,
    input  entry_byte, bit_cnt, elem_idx, vec_sel
  );
endinterface

// File: rtl/btn_conditioner.sv
// One active-low button: 2-FF synchronizer, consecutive-sample debouncer, registered press pulse.
module btn_conditioner #(
  parameter int DB_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          vld1_q, vld1_d;
  logic          vld2_q, vld2_d;
  logic          armed_q, armed_d;
  logic          level_q, level_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    // vld marks when sync2 holds a real sample rather than its reset value
    vld1_d  = 1'b1;
    vld2_d  = vld1_q;
    // a button held through reset must be seen released before it can fire
    armed_d = armed_q | (vld2_q & sync2_q);
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (int'(cnt_q) + 1 >= DB_CYCLES) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    prev_d  = level_q;
    press_d = prev_q & ~level_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      armed_q <= armed_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/vector_entry_ctrl.sv
// Assembles MSB-first button bits into bytes and fills vector A then vector B.
module vector_entry_ctrl
  import term_project_pkg::*;
#(
  parameter int DB_CYCLES = 2,
  parameter int ELEMS     = 8
) (
  input  logic                CLK,
  input  logic                RST,
  vector_entry_ctrl_if.master bus
);
  localparam int IW = $clog2(ELEMS);
  localparam int VW = ELEMS * BYTE_W;

  logic [NUM_BTNS-1:0] btn_ev;
  logic                unused_btn;

  assign unused_btn = ^bus.btn_sw[7:4];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond (
        .clk   (CLK),
        .rst   (RST),
        .btn_n (bus.btn_sw[gi]),
        .press (btn_ev[gi])
      );
    end
  endgenerate

  entry_state_e      state_q, state_d;
  logic [BYTE_W-1:0] entry_byte_q, entry_byte_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]     elem_idx_q, elem_idx_d;
  logic [VW-1:0]     vec_a_q, vec_a_d;
  logic [VW-1:0]     vec_b_q, vec_b_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic              done_pulse_q, done_pulse_d;
  logic              vec_valid_q, vec_valid_d;
  logic              vec_sel_q, vec_sel_d;

  always_comb begin
    state_d      = state_q;
    entry_byte_d = entry_byte_q;
    bit_cnt_d    = bit_cnt_q;
    elem_idx_d   = elem_idx_q;
    vec_a_d      = vec_a_q;
    vec_b_d      = vec_b_q;
    wr_strobe_d  = 1'b0;
    done_pulse_d = 1'b0;

    // priority D > C > B > A; losers in the same cycle are dropped
    if (btn_ev[IDX_D]) begin
      state_d      = ENTER_A;
      entry_byte_d = '0;
      bit_cnt_d    = '0;
      elem_idx_d   = '0;
      vec_a_d      = '0;
      vec_b_d      = '0;
    end else if (btn_ev[IDX_C]) begin
      if (state_q != DONE) begin
        if (state_q == ENTER_A) begin
          vec_a_d[elem_idx_q*BYTE_W +: BYTE_W] = entry_byte_q;
        end else begin
          vec_b_d[elem_idx_q*BYTE_W +: BYTE_W] = entry_byte_q;
        end
        wr_strobe_d  = 1'b1;
        entry_byte_d = '0;
        bit_cnt_d    = '0;
        if (elem_idx_q == IW'(ELEMS - 1)) begin
          elem_idx_d = '0;
          if (state_q == ENTER_A) begin
            state_d = ENTER_B;
          end else begin
            state_d      = DONE;
            done_pulse_d = 1'b1;
          end
        end else begin
          elem_idx_d = elem_idx_q + 1'b1;
        end
      end
    end else if (btn_ev[IDX_B] || btn_ev[IDX_A]) begin
      if (state_q != DONE && bit_cnt_q < 4'(BYTE_W)) begin
        entry_byte_d = {entry_byte_q[BYTE_W-2:0], btn_ev[IDX_B]};
        bit_cnt_d    = bit_cnt_q + 1'b1;
      end
    end

    vec_valid_d = (state_d == DONE);
    vec_sel_d   = (state_d != ENTER_A);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ENTER_A;
      entry_byte_q <= '0;
      bit_cnt_q    <= '0;
      elem_idx_q   <= '0;
      vec_a_q      <= '0;
      vec_b_q      <= '0;
      wr_strobe_q  <= 1'b0;
      done_pulse_q <= 1'b0;
      vec_valid_q  <= 1'b0;
      vec_sel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_byte_q <= entry_byte_d;
      bit_cnt_q    <= bit_cnt_d;
      elem_idx_q   <= elem_idx_d;
      vec_a_q      <= vec_a_d;
      vec_b_q      <= vec_b_d;
      wr_strobe_q  <= wr_strobe_d;
      done_pulse_q <= done_pulse_d;
      vec_valid_q  <= vec_valid_d;
      vec_sel_q    <= vec_sel_d;
    end
  end

  assign bus.vec_a      = vec_a_q;
  assign bus.vec_b      = vec_b_q;
  assign bus.vec_valid  = vec_valid_q;
  assign bus.done_pulse = done_pulse_q;
  assign bus.wr_strobe  = wr_strobe_q;
  assign bus.entry_byte = entry_byte_q;
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.elem_idx   = elem_idx_q;
  assign bus.vec_sel    = vec_sel_q;

endmodule

// File: tb/tb_vector_entry_ctrl.sv
// Randomized scoreboard bench for vector_entry_ctrl against a byte/array-level entry model.
module tb_vector_entry_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  vector_entry_ctrl_if #(.ELEMS(8)) bus ();

  vector_entry_ctrl #(.DB_CYCLES(2), .ELEMS(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int sel;
    int idx;
    int val;
    bit done;
  } commit_t;

  commit_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_done = 0;

  // reference model: phase 0 = filling A, 1 = filling B, 2 = complete
  int m_phase, m_idx, m_nbits, m_cur;
  int m_a[8];
  int m_b[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_idx = 0; m_nbits = 0; m_cur = 0;
    for (int k = 0; k < 8; k++) begin
      m_a[k] = 0;
      m_b[k] = 0;
    end
  endfunction

  function automatic void model_event(input logic [3:0] mask);
    commit_t c;
    if (mask[3]) begin
      model_reset();
    end else if (mask[2]) begin
      if (m_phase < 2) begin
        if (m_phase == 0) m_a[m_idx] = m_cur;
        else m_b[m_idx] = m_cur;
        c.sel = m_phase; c.idx = m_idx; c.val = m_cur; c.done = 1'b0;
        m_idx++;
        if (m_idx == 8) begin
          m_idx = 0;
          m_phase++;
          c.done = (m_phase == 2);
        end
        m_cur = 0;
        m_nbits = 0;
        exp_q.push_back(c);
      end
    end else if (mask[1] || mask[0]) begin
      if (m_phase < 2 && m_nbits < 8) begin
        m_cur = (m_cur * 2 + (mask[1] ? 1 : 0)) % 256;
        m_nbits++;
      end
    end
  endfunction

  task automatic check_state(input string tag);
    logic [63:0] ea, eb;
    for (int k = 0; k < 8; k++) begin
      ea[k*8 +: 8] = 8'(m_a[k]);
      eb[k*8 +: 8] = 8'(m_b[k]);
    end
    chk({tag, ".entry_byte"}, 64'(bus.entry_byte), 64'(m_cur));
    chk({tag, ".bit_cnt"}, 64'(bus.bit_cnt), 64'(m_nbits));
    chk({tag, ".elem_idx"}, 64'(bus.elem_idx), 64'(m_idx));
    chk({tag, ".vec_sel"}, 64'(bus.vec_sel), 64'(m_phase != 0));
    chk({tag, ".vec_valid"}, 64'(bus.vec_valid), 64'(m_phase == 2));
    chk({tag, ".vec_a"}, bus.vec_a, ea);
    chk({tag, ".vec_b"}, bus.vec_b, eb);
  endtask

  // low for 'hold' cycles, then released for 'rel' cycles; model updated at issue time
  task automatic press_btn(input logic [3:0] mask, input int hold, input int rel);
    logic [3:0] noise;
    noise = 4'($urandom_range(0, 15));
    if (hold >= 3) model_event(mask);
    @(negedge CLK);
    bus.btn_sw = {noise, ~mask};
    repeat (hold) @(negedge CLK);
    bus.btn_sw = {noise, 4'hF};
    repeat (rel) @(negedge CLK);
  endtask

  task automatic send_byte(input int v, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      press_btn(((v >> i) & 1) != 0 ? 4'b0010 : 4'b0001, 5, 5);
    end
    press_btn(4'b0100, 5, 5);
  endtask

  // monitor: pops one expected commit per wr_strobe
  initial begin
    commit_t e;
    logic [7:0] got;
    forever begin
      @(negedge CLK);
      if (RST === 1'b0) begin
        if (bus.done_pulse === 1'b1) n_done++;
        if (bus.wr_strobe === 1'b1) begin
          n_wr++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr_strobe: got wr_strobe=1 required no commit");
          end else begin
            e = exp_q.pop_front();
            got = (e.sel != 0) ? bus.vec_b[e.idx*8 +: 8] : bus.vec_a[e.idx*8 +: 8];
            chk("commit_byte", 64'(got), 64'(e.val));
            chk("commit_done_pulse", 64'(bus.done_pulse), 64'(e.done));
            chk("commit_bit_cnt_clr", 64'(bus.bit_cnt), 64'd0);
            $display("commit vec=%s elem=%0d byte=%02h done=%0b", (e.sel != 0) ? "B" : "A",
                     e.idx, got, bus.done_pulse);
          end
        end else begin
          chk("done_without_wr", 64'(bus.done_pulse), 64'd0);
        end
      end
    end
  end

  initial begin
    int wr0, r;
    logic [3:0] m;
    bus.btn_sw = 8'hFF;
    model_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_state("reset");
    chk("reset.wr_strobe", 64'(bus.wr_strobe), 64'd0);
    chk("reset.done_pulse", 64'(bus.done_pulse), 64'd0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // full entry A=[1,0..], B=[5,0..]
    wr0 = n_wr;
    for (int k = 0; k < 16; k++) begin
      send_byte((k == 0) ? 1 : (k == 8) ? 5 : 0, 8);
    end
    repeat (4) @(negedge CLK);
    chk("full.vec_a", bus.vec_a, 64'h1);
    chk("full.vec_b", bus.vec_b, 64'h5);
    chk("full.vec_valid", 64'(bus.vec_valid), 64'd1);
    chk("full.wr_count", 64'(n_wr - wr0), 64'd16);
    chk("full.done_count", 64'(n_done), 64'd1);
    check_state("full");

    // lockout in DONE
    press_btn(4'b0001, 5, 5); check_state("lock_a");
    press_btn(4'b0010, 5, 5); check_state("lock_b");
    press_btn(4'b0100, 5, 5); check_state("lock_c");
    chk("lock.wr_count", 64'(n_wr - wr0), 64'd16);

    press_btn(4'b1000, 5, 5);
    check_state("soft_rst_done");

    // partial byte B, A, C
    press_btn(4'b0010, 5, 5);
    press_btn(4'b0001, 5, 5);
    press_btn(4'b0100, 5, 5);
    chk("partial.elem0", 64'(bus.vec_a[7:0]), 64'h02);
    chk("partial.bit_cnt", 64'(bus.bit_cnt), 64'd0);
    chk("partial.elem_idx", 64'(bus.elem_idx), 64'd1);

    // overflow: nine B then C
    for (int i = 0; i < 9; i++) press_btn(4'b0010, 5, 5);
    chk("overflow.bit_cnt", 64'(bus.bit_cnt), 64'd8);
    check_state("overflow");
    press_btn(4'b0100, 5, 5);
    chk("overflow.elem1", 64'(bus.vec_a[15:8]), 64'hFF);

    // glitch: 1-cycle low on A is rejected
    press_btn(4'b0001, 1, 6);
    check_state("glitch");

    // third byte then soft reset via D
    send_byte(8'h3C, 8);
    check_state("three_bytes");
    press_btn(4'b1000, 5, 5);
    check_state("soft_rst");

    // RST while B held: no event until released and pressed again
    press_btn(4'b0001, 5, 5);
    model_event(4'b0010);
    @(negedge CLK);
    bus.btn_sw = 8'hFD;
    repeat (8) @(negedge CLK);
    check_state("held_before_rst");
    RST = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    check_state("held_after_rst");
    bus.btn_sw = 8'hFF;
    repeat (6) @(negedge CLK);
    check_state("released_after_rst");
    press_btn(4'b0010, 5, 5);
    check_state("repress_after_rst");

    // simultaneous presses: highest priority wins
    press_btn(4'b0101, 5, 5); check_state("simul_ca");
    press_btn(4'b0011, 5, 5); check_state("simul_ba");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30) m = 4'b0001;
      else if (r < 60) m = 4'b0010;
      else if (r < 93) m = 4'b0100;
      else if (r < 96) m = 4'b1000;
      else m = 4'($urandom_range(1, 15));
      press_btn(m, $urandom_range(3, 6), $urandom_range(4, 6));
      check_state("rand");
    end

    repeat (10) @(negedge CLK);
    chk("pending_commits", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
